// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: advances a hold/rotate/bounce/count pattern on each
// transition of the upstream blinker level and flags every completed cycle.
module led_pattern_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             KEY,
    input  logic             light,
    input  logic [1:0]       SW,
    output logic [WIDTH-1:0] LEDG,
    output logic             wrap
);

    localparam int PW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_ROT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_t;

    logic             r_light_q;
    mode_t            r_mode_q;
    logic [PW-1:0]    r_pos;
    logic             r_dir;
    logic [WIDTH-1:0] r_ledg;
    logic             r_wrap;

    logic             w_step;
    mode_t            w_sw;
    logic [PW-1:0]    w_pos_nxt;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_ledg_nxt;
    logic             w_wrap_nxt;

    assign w_step = (light != r_light_q);
    assign w_sw   = mode_t'(SW);

    // Next-state pattern logic; only a step cycle can change anything
    always_comb begin
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir;
        w_ledg_nxt = r_ledg;
        w_wrap_nxt = 1'b0;
        if (w_step) begin
            if (w_sw != r_mode_q) begin
                case (w_sw)
                    MODE_HOLD: w_ledg_nxt = r_ledg;
                    MODE_ROT:  w_ledg_nxt = WIDTH'(1);
                    MODE_BOUNCE: begin
                        w_ledg_nxt = WIDTH'(1);
                        w_pos_nxt  = PW'(0);
                        w_dir_nxt  = 1'b1;
                    end
                    MODE_COUNT: w_ledg_nxt = WIDTH'(0);
                    default:    w_ledg_nxt = r_ledg;
                endcase
            end else begin
                case (r_mode_q)
                    MODE_HOLD: w_ledg_nxt = r_ledg;
                    MODE_ROT: begin
                        w_ledg_nxt = {r_ledg[WIDTH-2:0], r_ledg[WIDTH-1]};
                        w_wrap_nxt = r_ledg[WIDTH-1];
                    end
                    MODE_BOUNCE: begin
                        if (r_dir) begin
                            if (r_pos >= PW'(WIDTH - 1)) begin
                                w_pos_nxt = PW'(WIDTH - 2);
                                w_dir_nxt = 1'b0;
                            end else begin
                                w_pos_nxt = r_pos + PW'(1);
                            end
                        end else begin
                            // pos 0 going down is unreachable; treat it like pos 1
                            if (r_pos <= PW'(1)) begin
                                w_pos_nxt  = PW'(0);
                                w_dir_nxt  = 1'b1;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_pos_nxt = r_pos - PW'(1);
                            end
                        end
                        w_ledg_nxt = WIDTH'(1) << w_pos_nxt;
                    end
                    MODE_COUNT: begin
                        w_ledg_nxt = r_ledg + WIDTH'(1);
                        w_wrap_nxt = &r_ledg;
                    end
                    default: w_ledg_nxt = r_ledg;
                endcase
            end
        end else begin
            w_wrap_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_light_q <= 1'b0;
            r_mode_q  <= MODE_HOLD;
            r_pos     <= PW'(0);
            r_dir     <= 1'b1;
            r_ledg    <= WIDTH'(0);
            r_wrap    <= 1'b0;
        end else begin
            r_light_q <= light;
            if (w_step) begin
                r_mode_q <= w_sw;
            end else begin
                r_mode_q <= r_mode_q;
            end
            r_pos  <= w_pos_nxt;
            r_dir  <= w_dir_nxt;
            r_ledg <= w_ledg_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign LEDG = r_ledg;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed plus randomized bench for led_pattern_seq against an arithmetic
// model of the pattern rules (bounce tracked as a phase around its full cycle).
module tb_led_pattern_seq;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk   = 1'b0;
    logic         KEY   = 1'b0;
    logic         light = 1'b0;
    logic [1:0]   SW    = 2'b00;
    logic [W-1:0] LEDG;
    logic         wrap;

    int n_pass  = 0;
    int n_total = 0;

    int         m_led;
    int         m_phase;
    logic       m_lightq;
    logic [1:0] m_mode;
    logic       m_wrap;

    led_pattern_seq #(.WIDTH(W)) dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .light    (light),
        .SW       (SW),
        .LEDG     (LEDG),
        .wrap     (wrap)
    );

    always #10 clk = ~clk;

    function automatic void model_reset();
        m_led    = 0;
        m_phase  = 0;
        m_lightq = 1'b0;
        m_mode   = 2'b00;
        m_wrap   = 1'b0;
    endfunction

    // One clock of the reference: what the outputs should be after the next edge
    function automatic void model_cycle(input logic l, input logic [1:0] sw);
        m_wrap = 1'b0;
        if (l != m_lightq) begin
            if (sw != m_mode) begin
                case (sw)
                    2'd1: m_led = 1;
                    2'd2: begin m_led = 1; m_phase = 0; end
                    2'd3: m_led = 0;
                    default: ;
                endcase
            end else begin
                case (sw)
                    2'd1: begin
                        m_wrap = (m_led == (1 << (W - 1)));
                        m_led  = ((m_led << 1) | (m_led >> (W - 1))) & MASK;
                    end
                    2'd2: begin
                        m_phase = (m_phase + 1) % (2 * (W - 1));
                        m_wrap  = (m_phase == 0);
                        m_led   = 1 << ((m_phase < W) ? m_phase : 2 * (W - 1) - m_phase);
                    end
                    2'd3: begin
                        m_wrap = (m_led == MASK);
                        m_led  = (m_led + 1) & MASK;
                    end
                    default: ;
                endcase
            end
            m_mode = sw;
        end
        m_lightq = l;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input bit tog, input logic [1:0] sw, input string tag);
        @(negedge clk);
        SW = sw;
        if (tog) light = ~light;
        model_cycle(light, sw);
        @(posedge clk);
        #1;
        check({tag, " LEDG"}, 32'(LEDG), 32'(m_led));
        check({tag, " wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    // Asserts KEY between edges, checks the asynchronous clear, releases before the next negedge
    task automatic reset_async(input string tag);
        @(posedge clk);
        #5;
        KEY   = 1'b0;
        light = 1'b0;
        model_reset();
        #1;
        check({tag, " rst LEDG"}, 32'(LEDG), 32'd0);
        check({tag, " rst wrap"}, 32'(wrap), 32'd0);
        @(posedge clk);
        #2;
        check({tag, " rst held LEDG"}, 32'(LEDG), 32'd0);
        #3;
        KEY = 1'b1;
    endtask

    initial begin
        logic [1:0] sw_r;
        model_reset();

        reset_async("init");
        repeat (5) cyc(1'b0, 2'd0, "idle");

        cyc(1'b1, 2'd1, "rot_load");
        check("rot_load_val", 32'(LEDG), 32'h01);
        repeat (8) cyc(1'b1, 2'd1, "rot");
        check("rot_end_val", 32'(LEDG), 32'h01);
        check("rot_wrap", 32'(wrap), 32'd1);

        cyc(1'b1, 2'd2, "bnc_load");
        repeat (14) cyc(1'b1, 2'd2, "bnc");
        check("bnc_end_val", 32'(LEDG), 32'h01);
        check("bnc_wrap", 32'(wrap), 32'd1);

        cyc(1'b1, 2'd3, "cnt_load");
        repeat (255) cyc(1'b1, 2'd3, "cnt");
        check("cnt_ff", 32'(LEDG), 32'hFF);
        cyc(1'b1, 2'd3, "cnt_wrap");
        check("cnt_wrap_hi", 32'(wrap), 32'd1);
        cyc(1'b0, 2'd3, "cnt_after");
        check("cnt_wrap_lo", 32'(wrap), 32'd0);

        cyc(1'b1, 2'd1, "gate_load");
        repeat (3) cyc(1'b1, 2'd1, "gate_rot");
        check("gate_at8", 32'(LEDG), 32'h08);
        repeat (50) cyc(1'b0, 2'd3, "gate_hold");
        check("gate_held", 32'(LEDG), 32'h08);
        cyc(1'b1, 2'd3, "gate_chg");
        check("gate_chg_val", 32'(LEDG), 32'h00);
        cyc(1'b1, 2'd3, "gate_next");
        check("gate_next_val", 32'(LEDG), 32'h01);

        cyc(1'b1, 2'd0, "b2b_hold");
        cyc(1'b1, 2'd3, "b2b_load");
        repeat (10) cyc(1'b1, 2'd3, "b2b");
        check("b2b_end", 32'(LEDG), 32'd10);

        repeat (32) cyc(1'b1, 2'd3, "to2a");
        check("at_2a", 32'(LEDG), 32'h2A);
        reset_async("mid");
        repeat (5) cyc(1'b0, 2'd0, "post_rst");

        sw_r = 2'd0;
        repeat (600) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_async("rand");
            end else begin
                if ($urandom_range(0, 9) == 0) sw_r = 2'($urandom_range(0, 3));
                cyc($urandom_range(0, 3) != 0, sw_r, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
